// File: rtl/spi_xfer_arbiter_pkg.sv
// spi_arb_pkg: shared state encoding, default width and clog2 helper for the SPI transfer arbiter
package spi_arb_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, LAUNCH = 2'd1, WAIT = 2'd2, RESP = 2'd3} arb_state_e;
    localparam int DEF_DATA_W = 32;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/spi_xfer_arbiter_if.sv
// spi_xfer_arbiter_if: requester, response and SPI-top signals of the transfer arbiter
interface spi_xfer_arbiter_if import spi_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = DEF_DATA_W
);
    localparam int IW = clog2(NUM_REQ);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic rsp_err;
    logic busy;
    logic [IW-1:0] grant_id;
    logic spi_trigger;
    logic [DATA_W-1:0] spi_din;
    logic [DATA_W-1:0] spi_dout;
    logic spi_done;
    modport slave (
        input req_valid, req_data, spi_dout, spi_done,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy, grant_id, spi_trigger, spi_din
    );
    modport master (
        output req_valid, req_data, spi_dout, spi_done,
        input req_ready, rsp_valid, rsp_data, rsp_err, busy, grant_id, spi_trigger, spi_din
    );
endinterface

// File: rtl/spi_xfer_arbiter_rr_picker.sv
// spi_rr_picker: round-robin winner select by rotate, lowest-index priority encode, un-rotate
module spi_rr_picker import spi_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    localparam int IW = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic               any_req,
    output logic [IW-1:0]      winner
);
    logic [NUM_REQ-1:0] rot;
    logic [IW-1:0] idx;
    logic [IW:0] sum;
    assign rot = NUM_REQ'({req, req} >> ptr);
    assign any_req = |req;
    always_comb begin
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) idx = rot[i] ? IW'(i) : idx;
    end
    assign sum = {1'b0, idx} + {1'b0, ptr};
    assign winner = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : sum[IW-1:0];
endmodule

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin owner of one SPI top link, launches a transfer and returns its word or a timeout error
module spi_xfer_arbiter import spi_arb_pkg::*; #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input logic clk,
    input logic rst_n,
    spi_xfer_arbiter_if.slave bus
);
    localparam int IW = clog2(NUM_REQ);
    localparam int CW = clog2(TIMEOUT + 1);
    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_LAUNCH = LAUNCH;
    localparam logic [1:0] ST_WAIT = WAIT;
    localparam logic [1:0] ST_RESP = RESP;
    logic [1:0] state;
    logic [IW-1:0] ptr, gid, win, next_ptr;
    logic [CW-1:0] cnt;
    logic [DATA_W-1:0] din_q, rdata_q;
    logic err_q, any, accept;
    spi_rr_picker #(.NUM_REQ(NUM_REQ)) u_pick (
        .req(bus.req_valid),
        .ptr(ptr),
        .any_req(any),
        .winner(win)
    );
    assign accept = rst_n && (state == ST_IDLE) && any;
    assign next_ptr = (gid == IW'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr <= '0;
            cnt <= '0;
            gid <= '0;
            din_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (any) begin
                    din_q <= bus.req_data[win*DATA_W +: DATA_W];
                    gid <= win;
                    state <= ST_LAUNCH;
                end
                ST_LAUNCH: begin
                    cnt <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: if (bus.spi_done) begin
                    rdata_q <= bus.spi_dout;
                    err_q <= 1'b0;
                    state <= ST_RESP;
                end else if (cnt == CW'(TIMEOUT)) begin
                    rdata_q <= '0;
                    err_q <= 1'b1;
                    state <= ST_RESP;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    ptr <= next_ptr;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
    assign bus.req_ready = accept ? (NUM_REQ'(1) << win) : '0;
    assign bus.rsp_valid = (state == ST_RESP) ? (NUM_REQ'(1) << gid) : '0;
    assign bus.rsp_data = rdata_q;
    assign bus.rsp_err = err_q;
    assign bus.busy = state != ST_IDLE;
    assign bus.grant_id = gid;
    assign bus.spi_trigger = state == ST_LAUNCH;
    assign bus.spi_din = din_q;
endmodule
